// File: rtl/sync_fifo_8x16.sv
// ---------------------------------------------------------------------------
// sync_fifo_8x16
// Single-clock FIFO with registered (non-fall-through) read data.
// Write and read pointers carry one extra wrap bit above the address bits,
// so full and empty are told apart without spending a storage entry.
// full, empty and data_count are registered from next-state values, so no
// combinational path runs from wr_en/rd_en to any status output.
// overflow/underflow are one-cycle pulses that flag a request rejected at
// the previous edge.
// ---------------------------------------------------------------------------
module sync_fifo_8x16 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,            // power of two, at least 2
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W:0]    PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  // Storage and state
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]       r_wr_ptr;
  logic [ADDR_W:0]       r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_full;
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_overflow;
  logic                  r_underflow;

  // Accept/reject decisions and next-state values
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_wr_rej;
  logic                  w_rd_rej;
  logic [ADDR_W:0]       w_wr_ptr_nxt;
  logic [ADDR_W:0]       w_rd_ptr_nxt;
  logic [CNT_WIDTH-1:0]  w_count_nxt;
  logic                  w_full_nxt;
  logic                  w_empty_nxt;

  // Acceptance uses the registered flags, i.e. the state before the edge,
  // so a simultaneous read never frees room for a write in the same cycle.
  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;
  assign w_wr_rej = wr_en &&  r_full;
  assign w_rd_rej = rd_en &&  r_empty;

  // Next pointer, count and flag values for the coming edge
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;

    if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;

    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase

    // Same address with a different wrap bit means the writer has lapped the
    // reader by exactly DEPTH entries; identical pointers mean nothing stored.
    w_full_nxt  = (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]) &&
                  (w_wr_ptr_nxt[ADDR_W]     != w_rd_ptr_nxt[ADDR_W]);
    w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  end

  // Storage write; the array holds no reset so it can map onto plain RAM
  // NOTE: the memory is deliberately left out of the reset; stale contents
  // are unreachable because the pointers reset to equal (empty) values.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
  end

  // Pointers, occupancy and status flags
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
    end
  end

  // Registered read data; holds its value when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rd_ptr[ADDR_W-1:0]];
    end
  end

  // One-cycle error pulses for requests rejected at this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_wr_rej;
      r_underflow <= w_rd_rej;
    end
  end

  assign dout       = r_dout;
  assign full       = r_full;
  assign empty      = r_empty;
  assign data_count = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

  // The count and the pointer-derived flags must always tell the same story.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (r_count <= CNT_FULL)
        else $error("data_count above DEPTH");
      assert (r_full == (r_count == CNT_FULL))
        else $error("full disagrees with data_count");
      assert (r_empty == (r_count == '0))
        else $error("empty disagrees with data_count");
    end
  end

endmodule

// File: tb/tb_sync_fifo_8x16.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_8x16
// Directed bench for sync_fifo_8x16. Inputs change 1 ns after each rising
// edge and outputs are sampled at that same point, well clear of the edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo_8x16;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic [4:0] data_count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_8x16 #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .CNT_WIDTH  (5)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then settle just past the rising edge
  task automatic step(input logic wr, input logic rd, input logic [7:0] d);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Check the whole status word in one go
  task automatic check_status(input string tag, input int cnt, input int f,
                              input int e);
    check({tag, ".count"}, int'(data_count), cnt);
    check({tag, ".full"},  int'(full),       f);
    check({tag, ".empty"}, int'(empty),      e);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;

    // Reset held for 10 cycles
    repeat (10) @(posedge clk);
    #1;
    check_status("rst", 0, 0, 1);
    check("rst.dout", int'(dout),      'h00);
    check("rst.ovf",  int'(overflow),  0);
    check("rst.unf",  int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check_status("idle", 0, 0, 1);
    check("idle.dout", int'(dout), 'h00);

    // Burst of 11 writes, 2 idle, then 4 reads
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(i));
    check_status("burst.wr", 11, 0, 0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("burst.rd%0d", i), int'(dout), i);
    end
    check_status("burst.after", 7, 0, 0);
    for (int i = 4; i < 11; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain.rd%0d", i), int'(dout), i);
    end
    check_status("drain", 0, 0, 1);

    // Fill to 16 then one extra write that must be dropped
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    check_status("fill", 16, 1, 0);
    check("fill.ovf0", int'(overflow), 0);
    step(1'b1, 1'b0, 8'h20);
    check("fill.ovf", int'(overflow), 1);
    check_status("fill.rej", 16, 1, 0);
    step(1'b0, 1'b0, 8'h00);
    check("fill.ovf_clr", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("fill.rd%0d", i), int'(dout), 'h10 + i);
    end
    check_status("fill.empty", 0, 0, 1);

    // Read from empty: underflow pulse, dout held
    step(1'b0, 1'b1, 8'h00);
    check("unf.pulse", int'(underflow), 1);
    check("unf.dout",  int'(dout),      'h1F);
    check("unf.count", int'(data_count), 0);
    step(1'b0, 1'b0, 8'h00);
    check("unf.clr",   int'(underflow), 0);

    // Simultaneous read/write at count 5, 20 cycles across the wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    check_status("rw.pre", 5, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h45 + i));
      check($sformatf("rw.dout%0d", i), int'(dout), 'h40 + i);
      check($sformatf("rw.cnt%0d", i), int'(data_count), 5);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("rw.tail%0d", i), int'(dout), 'h54 + i);
    end
    check_status("rw.empty", 0, 0, 1);

    // Simultaneous read/write when full: write rejected, read accepted
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    check_status("frw.pre", 16, 1, 0);
    step(1'b1, 1'b1, 8'hEE);
    check_status("frw", 15, 0, 0);
    check("frw.dout", int'(dout),     'h60);
    check("frw.ovf",  int'(overflow), 1);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("frw.rd%0d", i), int'(dout), 'h60 + i);
    end
    check_status("frw.empty", 0, 0, 1);

    // Asynchronous reset between edges with 8 entries stored
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    check_status("arst.pre", 8, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_status("arst", 0, 0, 1);
    check("arst.dout", int'(dout), 'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'hA5);
    check_status("arst.wr", 1, 0, 0);
    step(1'b0, 1'b1, 8'h00);
    check("arst.rd", int'(dout), 'hA5);
    check_status("arst.rd", 0, 0, 1);

    // Simultaneous read/write when empty: write accepted, read rejected
    step(1'b1, 1'b1, 8'h33);
    check_status("erw", 1, 0, 0);
    check("erw.unf",  int'(underflow), 1);
    check("erw.dout", int'(dout),      'hA5);
    step(1'b0, 1'b1, 8'h00);
    check("erw.rd",   int'(dout),      'h33);
    check("erw.unf_clr", int'(underflow), 0);
    check_status("erw.end", 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
